// File: rtl/stack_pkg.sv
// Shared defaults for the stack controller and the calculator top level that
// instantiates it.
//
// Contents:
//   DATA_WIDTH_DEF  default width of one stack entry
//   DEPTH_DEF       default number of entries (power of 2)
//   PTR_WIDTH_DEF   default stack pointer width, holds 0..DEPTH_DEF inclusive
//   is_pow2()       helper for callers that want to sanity-check a DEPTH
package stack_pkg;

  localparam int DATA_WIDTH_DEF = 4;
  localparam int DEPTH_DEF      = 8;
  // One extra bit so the pointer can represent "full" (== DEPTH) without
  // wrapping back to zero.
  localparam int PTR_WIDTH_DEF  = $clog2(DEPTH_DEF) + 1;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage : stack_pkg

// File: rtl/pulse_gen_edge.sv
// Rising-edge one-shot. Turns a held level into a single-cycle pulse that is
// high in the same cycle the level first appears (no added latency).
//
// Ports:
//   clk  in  1  system clock
//   rst  in  1  synchronous active-high reset; clears the history register
//   in   in  1  level input (e.g. a debounced button)
//   out  out 1  in & ~in_q : high for one cycle per rising edge of in
//
// Because reset clears the history to 0, a level held high through reset is
// seen as a fresh edge on the first cycle after reset is released.
module pulse_gen_edge (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  logic in_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in;
    end
  end

  assign out = in & ~in_q;

endmodule : pulse_gen_edge

// File: rtl/stack_ctrl_unit.sv
// LIFO stack controller for the RPN calculator datapath. Single-cycle push and
// pop, one-shot completion strobes, full/empty status and a visible stack
// pointer.
//
// Ports:
//   clk            in   1           system clock, all state on rising edge
//   rst            in   1           synchronous active-high reset
//   din            in   DATA_WIDTH  value written on an accepted push
//   push           in   1           push request (pulse, or level if EDGE_IN=1)
//   pop            in   1           pop request (pulse, or level if EDGE_IN=1)
//   dout           out  DATA_WIDTH  most recently popped value, registered
//   pushed         out  1           one-cycle strobe: push accepted
//   popped         out  1           one-cycle strobe: pop accepted, dout new
//   full           out  1           stack_pointer == DEPTH
//   empty          out  1           stack_pointer == 0
//   stack_pointer  out  PTR_WIDTH   number of valid entries
//
// Request/completion protocol: a request is sampled at a rising clk edge.
// It is accepted only if exactly one of push/pop is active and the stack can
// take it (push needs !full, pop needs !empty). An accepted request raises its
// strobe for exactly the one cycle after that edge; for a pop, dout carries
// the popped value from that same cycle onward. Rejected requests (overflow,
// underflow, push+pop together) leave every register untouched and produce no
// strobe. There is no back-pressure: the requester must watch full/empty.
//
// DEPTH must be a power of 2 so the low pointer bits index the memory
// directly.
module stack_ctrl_unit
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int PTR_WIDTH  = $clog2(DEPTH) + 1,
  parameter bit EDGE_IN    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  push,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  pushed,
  output logic                  popped,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_WIDTH-1:0]  stack_pointer
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic                  push_req;
  logic                  pop_req;
  logic                  do_push;
  logic                  do_pop;
  logic [PTR_WIDTH-1:0]  sp;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Optional input conditioning so raw button levels can drive the stack.
  generate
    if (EDGE_IN) begin : g_edge_in
      pulse_gen_edge u_push_edge (
        .clk (clk),
        .rst (rst),
        .in  (push),
        .out (push_req)
      );
      pulse_gen_edge u_pop_edge (
        .clk (clk),
        .rst (rst),
        .in  (pop),
        .out (pop_req)
      );
    end else begin : g_pulse_in
      assign push_req = push;
      assign pop_req  = pop;
    end
  endgenerate

  assign full  = (sp == PTR_WIDTH'(DEPTH));
  assign empty = (sp == '0);

  // Simultaneous push and pop cancel each other out.
  assign do_push = push_req & ~pop_req & ~full;
  assign do_pop  = pop_req & ~push_req & ~empty;

  // Write slot is sp itself (only used when sp < DEPTH). Read slot is sp-1;
  // computing it in ADDR_WIDTH bits wraps sp==DEPTH to the last slot, which
  // is exactly the top entry when full.
  assign wr_idx = sp[ADDR_WIDTH-1:0];
  assign rd_idx = wr_idx - 1'b1;

  // Control state. Reset wins over any same-cycle request.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp     <= '0;
      dout   <= '0;
      pushed <= 1'b0;
      popped <= 1'b0;
    end else begin
      pushed <= do_push;
      popped <= do_pop;
      if (do_push) begin
        sp <= sp + 1'b1;
      end else if (do_pop) begin
        sp   <= sp - 1'b1;
        dout <= mem[rd_idx];
      end
    end
  end

  // Storage is not cleared by reset; only the write is suppressed so a push
  // coinciding with reset leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_idx] <= din;
    end
  end

  assign stack_pointer = sp;

endmodule : stack_ctrl_unit

// File: tb/tb_stack_ctrl_unit.sv
// Bench for stack_ctrl_unit. Two instances: one with pulse inputs
// (EDGE_IN=0, prefix a_) and one with level inputs (EDGE_IN=1, prefix e_).
// Each is compared every cycle against a queue-based LIFO model.
module tb_stack_ctrl_unit;

  localparam int DW    = 4;
  localparam int DEPTH = 8;
  localparam int PW    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: pulse inputs ----------------
  logic          a_rst, a_push, a_pop;
  logic [DW-1:0] a_din, a_dout;
  logic          a_pushed, a_popped, a_full, a_empty;
  logic [PW-1:0] a_sp;

  stack_ctrl_unit #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(PW), .EDGE_IN(1'b0)) u_dut_a (
    .clk           (clk),
    .rst           (a_rst),
    .din           (a_din),
    .push          (a_push),
    .pop           (a_pop),
    .dout          (a_dout),
    .pushed        (a_pushed),
    .popped        (a_popped),
    .full          (a_full),
    .empty         (a_empty),
    .stack_pointer (a_sp)
  );

  // ---------------- DUT E: level inputs ----------------
  logic          e_rst, e_push, e_pop;
  logic [DW-1:0] e_din, e_dout;
  logic          e_pushed, e_popped, e_full, e_empty;
  logic [PW-1:0] e_sp;

  stack_ctrl_unit #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(PW), .EDGE_IN(1'b1)) u_dut_e (
    .clk           (clk),
    .rst           (e_rst),
    .din           (e_din),
    .push          (e_push),
    .pop           (e_pop),
    .dout          (e_dout),
    .pushed        (e_pushed),
    .popped        (e_popped),
    .full          (e_full),
    .empty         (e_empty),
    .stack_pointer (e_sp)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] a_q[$];
  logic [DW-1:0] a_exp_dout;
  logic          a_exp_pushed, a_exp_popped;

  logic [DW-1:0] e_q[$];
  logic [DW-1:0] e_exp_dout;
  logic          e_exp_pushed, e_exp_popped;
  logic          e_prev_push, e_prev_pop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_a(input string ctx);
    check({ctx, " sp"},     32'(a_sp),     32'(a_q.size()));
    check({ctx, " empty"},  32'(a_empty),  32'(a_q.size() == 0));
    check({ctx, " full"},   32'(a_full),   32'(a_q.size() == DEPTH));
    check({ctx, " dout"},   32'(a_dout),   32'(a_exp_dout));
    check({ctx, " pushed"}, 32'(a_pushed), 32'(a_exp_pushed));
    check({ctx, " popped"}, 32'(a_popped), 32'(a_exp_popped));
  endtask

  task automatic check_e(input string ctx);
    check({ctx, " sp"},     32'(e_sp),     32'(e_q.size()));
    check({ctx, " empty"},  32'(e_empty),  32'(e_q.size() == 0));
    check({ctx, " full"},   32'(e_full),   32'(e_q.size() == DEPTH));
    check({ctx, " dout"},   32'(e_dout),   32'(e_exp_dout));
    check({ctx, " pushed"}, 32'(e_pushed), 32'(e_exp_pushed));
    check({ctx, " popped"}, 32'(e_popped), 32'(e_exp_popped));
  endtask

  // ---------------- driver tasks: DUT A ----------------
  task automatic reset_a(input logic p, input logic q);
    a_rst = 1'b1; a_push = p; a_pop = q; a_din = DW'($urandom_range(0, 15));
    a_q.delete();
    a_exp_dout = '0; a_exp_pushed = 1'b0; a_exp_popped = 1'b0;
    @(posedge clk); #1;
    check_a("a_reset");
    a_rst = 1'b0; a_push = 1'b0; a_pop = 1'b0;
  endtask

  task automatic step_a(input string ctx, input logic p, input logic q, input logic [DW-1:0] d);
    a_push = p; a_pop = q; a_din = d;
    a_exp_pushed = 1'b0; a_exp_popped = 1'b0;
    if (p && !q && a_q.size() < DEPTH) begin
      a_q.push_back(d);
      a_exp_pushed = 1'b1;
    end else if (q && !p && a_q.size() > 0) begin
      a_exp_dout   = a_q.pop_back();
      a_exp_popped = 1'b1;
    end
    @(posedge clk); #1;
    check_a(ctx);
  endtask

  // ---------------- driver tasks: DUT E ----------------
  task automatic reset_e(input logic p, input logic q);
    e_rst = 1'b1; e_push = p; e_pop = q; e_din = DW'($urandom_range(0, 15));
    e_q.delete();
    e_prev_push = 1'b0; e_prev_pop = 1'b0;
    e_exp_dout = '0; e_exp_pushed = 1'b0; e_exp_popped = 1'b0;
    @(posedge clk); #1;
    check_e("e_reset");
    e_rst = 1'b0;
  endtask

  task automatic step_e(input string ctx, input logic p, input logic q, input logic [DW-1:0] d);
    logic rp, rq;
    e_push = p; e_pop = q; e_din = d;
    rp = p && !e_prev_push;
    rq = q && !e_prev_pop;
    e_prev_push = p; e_prev_pop = q;
    e_exp_pushed = 1'b0; e_exp_popped = 1'b0;
    if (rp && !rq && e_q.size() < DEPTH) begin
      e_q.push_back(d);
      e_exp_pushed = 1'b1;
    end else if (rq && !rp && e_q.size() > 0) begin
      e_exp_dout   = e_q.pop_back();
      e_exp_popped = 1'b1;
    end
    @(posedge clk); #1;
    check_e(ctx);
  endtask

  // ---------------- stimulus: DUT A ----------------
  logic a_done = 1'b0;
  logic e_done = 1'b0;

  initial begin
    a_rst = 1'b1; a_push = 1'b0; a_pop = 1'b0; a_din = '0;
    // 1. reset with a push pending (reset wins), then idle
    reset_a(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step_a("a_idle", 1'b0, 1'b0, DW'(i));

    // 2. push 3, 5; pop twice -> 5 then 3
    step_a("a_push3", 1'b1, 1'b0, 4'd3);
    step_a("a_push5", 1'b1, 1'b0, 4'd5);
    step_a("a_gap",   1'b0, 1'b0, 4'd0);
    step_a("a_pop5",  1'b0, 1'b1, 4'd0);
    check("a_pop5 value", 32'(a_dout), 32'd5);
    step_a("a_pop3",  1'b0, 1'b1, 4'd0);
    check("a_pop3 value", 32'(a_dout), 32'd3);
    step_a("a_hold",  1'b0, 1'b0, 4'd9);

    // 3. fill with 1..8, overflow push of F, drain
    for (int i = 1; i <= DEPTH; i++) step_a("a_fill", 1'b1, 1'b0, DW'(i));
    check("a_full at 8", 32'(a_full), 32'd1);
    step_a("a_overflow", 1'b1, 1'b0, 4'hF);
    check("a_overflow sp", 32'(a_sp), 32'd8);
    for (int i = DEPTH; i >= 1; i--) begin
      step_a("a_drain", 1'b0, 1'b1, 4'd0);
      check("a_drain order", 32'(a_dout), 32'(i));
    end

    // 4. underflow pop, push+pop together (empty and non-empty)
    step_a("a_underflow", 1'b0, 1'b1, 4'd0);
    step_a("a_both_empty", 1'b1, 1'b1, 4'd7);
    step_a("a_push_c", 1'b1, 1'b0, 4'hC);
    step_a("a_both", 1'b1, 1'b1, 4'd2);
    step_a("a_pop_c", 1'b0, 1'b1, 4'd0);
    check("a_pop_c value", 32'(a_dout), 32'hC);

    // random traffic, biased to reach both boundaries
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (i % 100 == 57) begin
        reset_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        logic p, q;
        if ((i / 60) % 2 == 0) begin
          p = (r < 55); q = (r >= 45 && r < 80);
        end else begin
          p = (r < 25); q = (r >= 15 && r < 75);
        end
        step_a("a_rand", p, q, DW'($urandom_range(0, 15)));
      end
    end
    a_push = 1'b0; a_pop = 1'b0;
    a_done = 1'b1;
  end

  // ---------------- stimulus: DUT E ----------------
  initial begin
    e_rst = 1'b1; e_push = 1'b0; e_pop = 1'b0; e_din = '0;
    e_prev_push = 1'b0; e_prev_pop = 1'b0;
    reset_e(1'b0, 1'b0);
    e_push = 1'b0; e_pop = 1'b0;

    // 5a. push held 5 cycles with din=6 -> single push
    for (int i = 0; i < 5; i++) step_e("e_hold", 1'b1, 1'b0, 4'd6);
    check("e_hold sp", 32'(e_sp), 32'd1);

    // build up to sp=3 with separate edges
    step_e("e_rel",  1'b0, 1'b0, 4'd0);
    step_e("e_p2",   1'b1, 1'b0, 4'd2);
    step_e("e_rel",  1'b0, 1'b0, 4'd0);
    step_e("e_p3",   1'b1, 1'b0, 4'd3);
    check("e_sp3", 32'(e_sp), 32'd3);

    // held pop: one pop only
    step_e("e_rel",  1'b0, 1'b0, 4'd0);
    step_e("e_pop",  1'b0, 1'b1, 4'd0);
    step_e("e_poph", 1'b0, 1'b1, 4'd0);
    step_e("e_poph", 1'b0, 1'b1, 4'd0);
    check("e_pop once", 32'(e_sp), 32'd2);
    step_e("e_rel",  1'b0, 1'b0, 4'd0);
    step_e("e_p4",   1'b1, 1'b0, 4'd4);

    // 5b. reset mid-stream at sp=3 with push held through reset
    reset_e(1'b1, 1'b0);
    check("e_rst sp", 32'(e_sp), 32'd0);
    check("e_rst empty", 32'(e_empty), 32'd1);
    step_e("e_after_rst", 1'b1, 1'b0, 4'd9);
    check("e_after_rst sp", 32'(e_sp), 32'd1);
    step_e("e_after_rst_hold", 1'b1, 1'b0, 4'd9);

    // random levels
    for (int i = 0; i < 400; i++) begin
      int r;
      logic p, q;
      r = int'($urandom_range(0, 99));
      p = (r < 50);
      q = ((i / 80) % 2 == 0) ? (r >= 70) : (r >= 35 && r < 90);
      step_e("e_rand", p, q, DW'($urandom_range(0, 15)));
    end
    e_push = 1'b0; e_pop = 1'b0;
    e_done = 1'b1;
  end

  // ---------------- final report ----------------
  initial begin
    int cycles;
    cycles = 0;
    while (!(a_done && e_done) && cycles < 5000) begin
      @(posedge clk);
      cycles++;
    end
    if (!(a_done && e_done)) begin
      check("stimulus_timeout", 32'(cycles), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_stack_ctrl_unit
